// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator.
//   - led_mode_e     : per-channel mode encoding (OFF/ON/BLINK/ONESHOT)
//   - LED_MODE_WIDTH : bits per channel in the packed mode bus
//   - LED_DUTY_WIDTH : bits per channel in the packed duty bus (PWM dimming build)
//   - clogb2()       : bits needed to count 0..value-1 (minimum 1)
package led_pattern_pkg;

  localparam int unsigned LED_MODE_WIDTH = 2;
  localparam int unsigned LED_DUTY_WIDTH = 4;

  typedef enum logic [LED_MODE_WIDTH-1:0] {
    LED_MODE_OFF     = 2'd0,
    LED_MODE_ON      = 2'd1,
    LED_MODE_BLINK   = 2'd2,
    LED_MODE_ONESHOT = 2'd3
  } led_mode_e;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Channel-control bundle for led_pattern_gen.
//   master : drives ch_mode, ch_period, ch_trig (and ch_duty); observes tick, ch_busy, led_out
//   slave  : the generator itself
// Build option: LED_PWM_DIM_EN adds the per-channel ch_duty field.
interface led_pattern_gen_if
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned PERIOD_WIDTH = 12
) ();

  logic [LED_MODE_WIDTH*NUM_CH-1:0] ch_mode;
  logic [PERIOD_WIDTH*NUM_CH-1:0]   ch_period;
  logic [NUM_CH-1:0]                ch_trig;
`ifdef LED_PWM_DIM_EN
  logic [LED_DUTY_WIDTH*NUM_CH-1:0] ch_duty;
`endif
  logic                             tick;
  logic [NUM_CH-1:0]                ch_busy;
  logic [NUM_CH-1:0]                led_out;

  modport master (
`ifdef LED_PWM_DIM_EN
    output ch_duty,
`endif
    output ch_mode, ch_period, ch_trig,
    input  tick, ch_busy, led_out
  );

  modport slave (
`ifdef LED_PWM_DIM_EN
    input  ch_duty,
`endif
    input  ch_mode, ch_period, ch_trig,
    output tick, ch_busy, led_out
  );

endinterface

// File: rtl/led_pattern_gen_tick_prescaler.sv
// tick_prescaler: divides CLK down to a one-cycle TICK every TICK_MAX cycles,
// TICK_MAX = CLOCK_FREQ_MHZ * TICK_USEC (>= 2).
//   CLK   in  clock
//   RESET in  asynchronous reset, active-high
//   TICK  out registered one-cycle pulse
// The count is split into a low segment of SEG_WIDTH bits and an upper remainder; the carry
// between them is registered so no long increment chain spans the whole counter.
module tick_prescaler
  import led_pattern_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_MHZ = 250,
  parameter int unsigned TICK_USEC      = 1000,
  parameter int unsigned SEG_WIDTH      = 8
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  localparam int unsigned TickMax  = CLOCK_FREQ_MHZ * TICK_USEC;
  localparam int unsigned CntWidth = clogb2(TickMax);
  localparam int unsigned LoWidth  = (CntWidth > SEG_WIDTH) ? SEG_WIDTH : CntWidth;
  localparam int unsigned HiWidth  = (CntWidth > LoWidth) ? CntWidth - LoWidth : 1;
  localparam logic [CntWidth-1:0] CmpVal = CntWidth'(TickMax - 2);

  logic [LoWidth-1:0]  lo_q, lo_d;
  logic [HiWidth-1:0]  hi_q, hi_d;
  logic                carry_q, carry_d;
  logic                tick_q, tick_d;
  logic [CntWidth-1:0] cnt;

  // With a single segment the upper part is a dummy bit that the cast drops.
  assign cnt = CntWidth'({hi_q, lo_q});

  always_comb begin
    // Decided one cycle early so TICK itself is a plain flop.
    tick_d = (cnt == CmpVal);
    if (tick_q) begin
      lo_d = '0;
      hi_d = '0;
    end else begin
      lo_d = lo_q + 1'b1;
      hi_d = carry_q ? hi_q + 1'b1 : hi_q;
    end
    // carry_q is high exactly while the low segment sits at all-ones.
    carry_d = (lo_d == '1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lo_q    <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      tick_q  <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator.
//   CLK   in  clock
//   RESET in  asynchronous reset, active-high
//   bus   led_pattern_gen_if.slave:
//           ch_mode   per-channel mode (OFF/ON/BLINK/ONESHOT)
//           ch_period BLINK half-period / ONESHOT length in ticks (0 acts as 1)
//           ch_trig   ONESHOT trigger, rising edge acts
//           ch_duty   per-channel 4-bit duty (LED_PWM_DIM_EN builds only)
//           tick      shared one-cycle tick
//           ch_busy   ONESHOT pulse in progress
//           led_out   registered LED drive
// Build option: LED_PWM_DIM_EN enables 16-step PWM dimming of led_out.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_MHZ = 250,
  parameter int unsigned TICK_USEC      = 1000,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PERIOD_WIDTH   = 12,
  parameter int unsigned SEG_WIDTH      = 8
) (
  input logic               CLK,
  input logic               RESET,
  led_pattern_gen_if.slave  bus
);

  logic              tick;
  logic [NUM_CH-1:0] led_vec;
  logic [NUM_CH-1:0] busy_vec;

  tick_prescaler #(
    .CLOCK_FREQ_MHZ (CLOCK_FREQ_MHZ),
    .TICK_USEC      (TICK_USEC),
    .SEG_WIDTH      (SEG_WIDTH)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (tick)
  );

  assign bus.tick    = tick;
  assign bus.led_out = led_vec;
  assign bus.ch_busy = busy_vec;

`ifdef LED_PWM_DIM_EN
  logic [LED_DUTY_WIDTH-1:0] frame_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) frame_q <= '0;
    else       frame_q <= frame_q + 1'b1;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_mode_e             mode, mode_q;
    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH:0]   cnt_inc;
    logic                    at_end;
    logic                    led_q, led_d;
    logic                    busy_q, busy_d;
    logic                    trig_q;
    logic                    rise;

    assign mode    = led_mode_e'(bus.ch_mode[i*LED_MODE_WIDTH +: LED_MODE_WIDTH]);
    assign period  = bus.ch_period[i*PERIOD_WIDTH +: PERIOD_WIDTH];
    assign cnt_inc = {1'b0, cnt_q} + {{PERIOD_WIDTH{1'b0}}, 1'b1};
    // cnt+1 is never below 1, so a zero period naturally behaves as one; the >= also
    // catches a period shrunk below the running count.
    assign at_end  = (cnt_inc >= {1'b0, period});
    assign rise    = bus.ch_trig[i] & ~trig_q;

    always_comb begin
      led_d  = led_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (mode != mode_q) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        led_d  = (mode == LED_MODE_ON) || (mode == LED_MODE_BLINK);
      end else begin
        unique case (mode)
          LED_MODE_OFF: begin
            led_d  = 1'b0;
            busy_d = 1'b0;
            cnt_d  = '0;
          end
          LED_MODE_ON: begin
            led_d  = 1'b1;
            busy_d = 1'b0;
            cnt_d  = '0;
          end
          LED_MODE_BLINK: begin
            busy_d = 1'b0;
            if (tick) begin
              if (at_end) begin
                led_d = ~led_q;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_inc[PERIOD_WIDTH-1:0];
              end
            end
          end
          LED_MODE_ONESHOT: begin
            // A fresh edge beats an end-of-pulse tick, so retriggering always extends.
            if (rise) begin
              led_d  = 1'b1;
              busy_d = 1'b1;
              cnt_d  = '0;
            end else if (busy_q && tick) begin
              if (at_end) begin
                led_d  = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
              end else begin
                cnt_d = cnt_inc[PERIOD_WIDTH-1:0];
              end
            end
          end
        endcase
      end
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        mode_q <= LED_MODE_OFF;
        cnt_q  <= '0;
        led_q  <= 1'b0;
        busy_q <= 1'b0;
        trig_q <= 1'b0;
      end else begin
        mode_q <= mode;
        cnt_q  <= cnt_d;
        led_q  <= led_d;
        busy_q <= busy_d;
        // Sampled in every mode so entering ONESHOT with the trigger held high is no edge.
        trig_q <= bus.ch_trig[i];
      end
    end

    assign busy_vec[i] = busy_q;

`ifdef LED_PWM_DIM_EN
    logic [LED_DUTY_WIDTH-1:0] duty;
    logic                      led_out_q;

    assign duty = bus.ch_duty[i*LED_DUTY_WIDTH +: LED_DUTY_WIDTH];

    // Built from led_d so dimming adds no latency over the undimmed build.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) led_out_q <= 1'b0;
      else       led_out_q <= led_d & ((duty == '1) | (frame_q < duty));
    end

    assign led_vec[i] = led_out_q;
`else
    assign led_vec[i] = led_q;
`endif
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: TICK every 10 cycles, 4 channels.
// Cycle index cyc = rising edges since RESET release; TICK is visible while cyc%10==9 and
// channels see it on edges where cyc%10==0.
module tb_led_pattern_gen;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  led_pattern_gen_if #(.NUM_CH(4), .PERIOD_WIDTH(12)) bus ();

  led_pattern_gen #(
    .CLOCK_FREQ_MHZ (1),
    .TICK_USEC      (10),
    .NUM_CH         (4),
    .PERIOD_WIDTH   (12),
    .SEG_WIDTH      (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned steps;
    logic [7:0]  mode;
    logic [47:0] period;
    logic [3:0]  trig;
    logic [3:0]  exp_led;
    logic [3:0]  exp_busy;
  } vec_t;

  // Periods packed {ch3, ch2, ch1, ch0}.
  localparam logic [47:0] PerA = {12'd0, 12'd8, 12'd4, 12'd3};
  localparam logic [47:0] PerB = {12'd0, 12'd8, 12'd4, 12'd0};
  localparam logic [47:0] PerC = {12'd0, 12'd2, 12'd4, 12'd0};

  vec_t vq[$];

  function automatic vec_t mk(input int unsigned steps, input logic [7:0] mode,
                              input logic [47:0] period, input logic [3:0] trig,
                              input logic [3:0] exp_led, input logic [3:0] exp_busy);
    vec_t v;
    v.steps    = steps;
    v.mode     = mode;
    v.period   = period;
    v.trig     = trig;
    v.exp_led  = exp_led;
    v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

`ifdef LED_PWM_DIM_EN
  task automatic count_high(input string name, input int exp);
    int highs;
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (bus.led_out[0]) highs++;
    end
    check(name, 32'(highs), 32'(exp));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog at cyc %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus.ch_mode   = '0;
    bus.ch_period = '0;
    bus.ch_trig   = '0;
`ifdef LED_PWM_DIM_EN
    bus.ch_duty   = '1;
`endif

    // Reset state and tick cadence with every channel OFF.
    do_reset();
    check("reset_tick", 32'(bus.tick), 32'd0);
    check("reset_led", 32'(bus.led_out), 32'd0);
    check("reset_busy", 32'(bus.ch_busy), 32'd0);
    for (int i = 1; i <= 40; i++) begin
      step(1);
      check("tick_cadence", 32'(bus.tick), (cyc % 10 == 9) ? 32'd1 : 32'd0);
      check("led_off", 32'(bus.led_out), 32'd0);
    end

    // Channel scenarios, hand-timed from a fresh reset.
    vq.push_back(mk( 1, 8'h02, PerA, 4'h0, 4'h1, 4'h0)); // 1   BLINK entry -> on
    vq.push_back(mk(28, 8'h02, PerA, 4'h0, 4'h1, 4'h0)); // 29
    vq.push_back(mk( 1, 8'h02, PerA, 4'h0, 4'h0, 4'h0)); // 30  third tick toggles
    vq.push_back(mk(29, 8'h02, PerA, 4'h0, 4'h0, 4'h0)); // 59
    vq.push_back(mk( 1, 8'h02, PerA, 4'h0, 4'h1, 4'h0)); // 60
    vq.push_back(mk( 9, 8'h02, PerB, 4'h0, 4'h1, 4'h0)); // 69  P=0
    vq.push_back(mk( 1, 8'h02, PerB, 4'h0, 4'h0, 4'h0)); // 70  toggles every tick
    vq.push_back(mk(10, 8'h02, PerB, 4'h0, 4'h1, 4'h0)); // 80
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h0, 4'h0, 4'h0)); // 81  ch0 OFF, ch1 ONESHOT
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 82  trigger edge
    vq.push_back(mk(37, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 119
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h2, 4'h0, 4'h0)); // 120 4th tick ends pulse
    vq.push_back(mk(20, 8'h0C, PerB, 4'h2, 4'h0, 4'h0)); // 140 held high: no repeat
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h0, 4'h0, 4'h0)); // 141
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 142 start
    vq.push_back(mk(18, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 160 two ticks in
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h0, 4'h2, 4'h2)); // 161
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 162 retrigger
    vq.push_back(mk(37, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 199 extended
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h2, 4'h0, 4'h0)); // 200 six ticks total
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h0, 4'h0, 4'h0)); // 201
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 202 start
    vq.push_back(mk(36, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 238
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h0, 4'h2, 4'h2)); // 239
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 240 edge on end tick
    vq.push_back(mk(39, 8'h0C, PerB, 4'h2, 4'h2, 4'h2)); // 279
    vq.push_back(mk( 1, 8'h0C, PerB, 4'h2, 4'h0, 4'h0)); // 280
    vq.push_back(mk( 1, 8'h6C, PerB, 4'h2, 4'hC, 4'h0)); // 281 ch2 BLINK P=8, ch3 ON
    vq.push_back(mk(54, 8'h6C, PerB, 4'h2, 4'hC, 4'h0)); // 335 ch2 cnt=5
    vq.push_back(mk( 1, 8'h2C, PerC, 4'h2, 4'h4, 4'h0)); // 336 P 8->2, ch3 OFF
    vq.push_back(mk( 3, 8'h2C, PerC, 4'h2, 4'h4, 4'h0)); // 339
    vq.push_back(mk( 1, 8'h2C, PerC, 4'h2, 4'h0, 4'h0)); // 340 toggles on next tick
    vq.push_back(mk(20, 8'h2C, PerC, 4'h2, 4'h4, 4'h0)); // 360
    vq.push_back(mk( 1, 8'h20, PerC, 4'h2, 4'h4, 4'h0)); // 361 ch1 OFF
    vq.push_back(mk( 2, 8'h2C, PerC, 4'h2, 4'h4, 4'h0)); // 363 re-enter: no edge

    do_reset();
    foreach (vq[i]) begin
      bus.ch_mode   = vq[i].mode;
      bus.ch_period = vq[i].period;
      bus.ch_trig   = vq[i].trig;
      step(vq[i].steps);
      check($sformatf("vec%0d_led", i), 32'(bus.led_out), 32'(vq[i].exp_led));
      check($sformatf("vec%0d_busy", i), 32'(bus.ch_busy), 32'(vq[i].exp_busy));
    end

    // Reset asserted mid-count while TICK and an LED are high clears them at once.
    step(6);
    check("pre_reset_tick", 32'(bus.tick), 32'd1);
    check("pre_reset_led", 32'(bus.led_out), 32'h4);
    rst = 1'b1;
    #1;
    check("async_reset_tick", 32'(bus.tick), 32'd0);
    check("async_reset_led", 32'(bus.led_out), 32'd0);
    check("async_reset_busy", 32'(bus.ch_busy), 32'd0);

`ifdef LED_PWM_DIM_EN
    bus.ch_mode   = 8'h01;
    bus.ch_period = '0;
    bus.ch_trig   = '0;
    bus.ch_duty   = 16'hFFF4;
    do_reset();
    step(2);
    count_high("pwm_duty4", 4);
    bus.ch_duty = 16'hFFF0;
    step(2);
    count_high("pwm_duty0", 0);
    bus.ch_duty = 16'hFFFF;
    step(2);
    count_high("pwm_duty15", 16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
